uart_cmd_parser: RTL and testbench

- Sits directly downstream of the UART receiver and consumes its received-byte output.
- Assembles received bytes into short ASCII command lines, e.g. "F3\r" or "S\n".
- Emits one decoded command pulse (code + 4-bit amount) or one error pulse per line.
- The pet-state logic consumes these pulses to update hunger/happiness/hygiene/energy, and can request a status dump.

---
 rtl/uart_cmd_parser.sv | 268 ++++++++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_parser
// Description : Assembles bytes from the UART receiver into short ASCII
//               command lines ("F3\r", "S\n", ...) and emits one decoded
//               command pulse (code + 4-bit amount) or one error pulse per
//               line. Includes an inter-byte timeout for abandoned lines.
//               Optional build macro CMD_LOWERCASE_EN: when defined, the
//               lowercase letters f/p/c/s/r alias their uppercase commands.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_parser #(
    parameter int TIMEOUT_CYCLES = 27000000,
    parameter int DEFAULT_ARG    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic [3:0] cmd_arg,
    output logic       cmd_err,
    output logic [1:0] err_code,
    output logic       busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [7:0] c_cr       = 8'h0D;
    localparam logic [7:0] c_lf       = 8'h0A;

    localparam logic [2:0] c_code_none  = 3'd0;
    localparam logic [2:0] c_code_feed  = 3'd1;
    localparam logic [2:0] c_code_play  = 3'd2;
    localparam logic [2:0] c_code_clean = 3'd3;
    localparam logic [2:0] c_code_sleep = 3'd4;
    localparam logic [2:0] c_code_stat  = 3'd5;
    localparam logic [2:0] c_code_reset = 3'd6;

    localparam logic [1:0] c_err_unknown = 2'd1;
    localparam logic [1:0] c_err_arg     = 2'd2;
    localparam logic [1:0] c_err_timeout = 2'd3;

    localparam logic [4:0] c_default_arg = 5'(DEFAULT_ARG);

    // Counter only needs to reach TIMEOUT_CYCLES-2 (the expiry is declared
    // one cycle early so the error pulse lands TIMEOUT_CYCLES after the
    // last accepted byte).
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_expire_at =
        CNT_W'((TIMEOUT_CYCLES >= 2) ? (TIMEOUT_CYCLES - 2) : 0);
    localparam logic [CNT_W-1:0] c_cnt_max   = '1;
    localparam logic             c_tmo_en    = (TIMEOUT_CYCLES != 0);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ARG1    = 3'd2,
        ST_ARG2    = 3'd3,
        ST_DISCARD = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    state_t             state_q,     state_d;
    logic [2:0]         code_q,      code_d;
    logic [4:0]         arg_q,       arg_d;
    logic [1:0]         pend_q,      pend_d;
    logic               prev_nz_q,   prev_nz_d;
    logic [CNT_W-1:0]   tmo_cnt_q,   tmo_cnt_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [2:0]         cmd_code_q,  cmd_code_d;
    logic [3:0]         cmd_arg_q,   cmd_arg_d;
    logic               cmd_err_q,   cmd_err_d;
    logic [1:0]         err_code_q,  err_code_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic       w_accept;
    logic       w_is_term;
    logic       w_is_digit;
    logic [3:0] w_digit;
    logic [2:0] w_letter_code;
    logic       w_code_takes_arg;
    logic [6:0] w_acc_wide;
    logic       w_expire;

    // Byte classification and the 0-to-nonzero accept edge
    always_comb begin
        w_accept         = (rx_byte != 8'h00) && !prev_nz_q;
        prev_nz_d        = (rx_byte != 8'h00);
        w_is_term        = (rx_byte == c_cr) || (rx_byte == c_lf);
        w_is_digit       = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
        w_digit          = rx_byte[3:0];
        w_code_takes_arg = (code_q == c_code_feed) || (code_q == c_code_play) ||
                           (code_q == c_code_clean);
        // arg_q is at most 9 whenever this is used, so 7 bits never wrap and
        // the >15 check sees the true value (e.g. "99" is rejected, not 3).
        w_acc_wide       = ({2'b00, arg_q} * 7'd10) + {3'b000, w_digit};
    end

    // Command letter decode; 0 means not a command letter
    always_comb begin
        w_letter_code = c_code_none;
        case (rx_byte)
            8'h46:   w_letter_code = c_code_feed;   // F
            8'h50:   w_letter_code = c_code_play;   // P
            8'h43:   w_letter_code = c_code_clean;  // C
            8'h53:   w_letter_code = c_code_sleep;  // S
            8'h3F:   w_letter_code = c_code_stat;   // ?
            8'h52:   w_letter_code = c_code_reset;  // R
`ifdef CMD_LOWERCASE_EN
            8'h66:   w_letter_code = c_code_feed;   // f
            8'h70:   w_letter_code = c_code_play;   // p
            8'h63:   w_letter_code = c_code_clean;  // c
            8'h73:   w_letter_code = c_code_sleep;  // s
            8'h72:   w_letter_code = c_code_reset;  // r
`else
`endif
            default: w_letter_code = c_code_none;
        endcase
    end

    // Inter-byte timeout counter: clears on any accept, counts while busy, saturates
    always_comb begin
        w_expire  = c_tmo_en && (state_q != ST_IDLE) && !w_accept &&
                    (tmo_cnt_q >= c_expire_at);
        tmo_cnt_d = tmo_cnt_q;
        if (w_accept) begin
            tmo_cnt_d = '0;
        end else if ((state_q != ST_IDLE) && (tmo_cnt_q != c_cnt_max)) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // Line-assembly FSM: next state, latched code/argument and output pulses
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        arg_d       = arg_q;
        pend_d      = pend_q;
        cmd_valid_d = 1'b0;
        cmd_code_d  = c_code_none;
        cmd_arg_d   = 4'd0;
        cmd_err_d   = 1'b0;
        err_code_d  = 2'd0;

        if (w_accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (w_is_term) begin
                        state_d = ST_IDLE;              // blank line / CR-LF pair
                    end else if (w_letter_code != c_code_none) begin
                        code_d  = w_letter_code;
                        arg_d   = 5'd0;
                        state_d = ST_CMD;
                    end else begin
                        pend_d  = c_err_unknown;
                        state_d = ST_DISCARD;
                    end
                end
                ST_CMD: begin
                    if (w_is_term) begin
                        cmd_valid_d = 1'b1;
                        cmd_code_d  = code_q;
                        cmd_arg_d   = w_code_takes_arg ? c_default_arg[3:0] : 4'd0;
                        state_d     = ST_IDLE;
                    end else if (w_is_digit && w_code_takes_arg) begin
                        arg_d   = {1'b0, w_digit};
                        state_d = ST_ARG1;
                    end else begin
                        pend_d  = c_err_arg;
                        state_d = ST_DISCARD;
                    end
                end
                ST_ARG1: begin
                    if (w_is_digit) begin
                        if (w_acc_wide > 7'd15) begin
                            pend_d  = c_err_arg;
                            state_d = ST_DISCARD;
                        end else begin
                            arg_d   = w_acc_wide[4:0];
                            state_d = ST_ARG2;
                        end
                    end else if (w_is_term) begin
                        cmd_valid_d = 1'b1;
                        cmd_code_d  = code_q;
                        cmd_arg_d   = arg_q[3:0];
                        state_d     = ST_IDLE;
                    end else begin
                        pend_d  = c_err_arg;
                        state_d = ST_DISCARD;
                    end
                end
                ST_ARG2: begin
                    if (w_is_term) begin
                        cmd_valid_d = 1'b1;
                        cmd_code_d  = code_q;
                        cmd_arg_d   = arg_q[3:0];
                        state_d     = ST_IDLE;
                    end else begin
                        pend_d  = c_err_arg;
                        state_d = ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (w_is_term) begin
                        cmd_err_d  = 1'b1;
                        err_code_d = pend_q;
                        state_d    = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (w_expire) begin
            // A byte accepted in the same cycle takes priority (branch above).
            cmd_err_d  = 1'b1;
            err_code_d = c_err_timeout;
            state_d    = ST_IDLE;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            code_q      <= c_code_none;
            arg_q       <= 5'd0;
            pend_q      <= 2'd0;
            prev_nz_q   <= 1'b1;        // a byte held through reset is never accepted
            tmo_cnt_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= c_code_none;
            cmd_arg_q   <= 4'd0;
            cmd_err_q   <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            arg_q       <= arg_d;
            pend_q      <= pend_d;
            prev_nz_q   <= prev_nz_d;
            tmo_cnt_q   <= tmo_cnt_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            cmd_arg_q   <= cmd_arg_d;
            cmd_err_q   <= cmd_err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign cmd_arg   = cmd_arg_q;
    assign cmd_err   = cmd_err_q;
    assign err_code  = err_code_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_parser
// Description : Directed self-checking bench for uart_cmd_parser. Instance A
//               uses the default (long) timeout for slow, held-byte traffic;
//               instance B uses TIMEOUT_CYCLES=100 for the timeout checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_parser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_a = 8'h00;
    logic [7:0] rx_b = 8'h00;

    logic       w_valid_a, w_err_a, w_busy_a;
    logic [2:0] w_code_a;
    logic [3:0] w_arg_a;
    logic [1:0] w_ecode_a;
    logic       w_valid_b, w_err_b, w_busy_b;
    logic [2:0] w_code_b;
    logic [3:0] w_arg_b;
    logic [1:0] w_ecode_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Pulse monitors (observe outputs only)
    int         vcnt_a = 0, ecnt_a = 0, vcnt_b = 0, ecnt_b = 0;
    logic [2:0] lcode_a = '0, lcode_b = '0;
    logic [3:0] larg_a = '0, larg_b = '0;
    logic [1:0] lerr_a = '0, lerr_b = '0;

    uart_cmd_parser u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .rx_byte   (rx_a),
        .cmd_valid (w_valid_a),
        .cmd_code  (w_code_a),
        .cmd_arg   (w_arg_a),
        .cmd_err   (w_err_a),
        .err_code  (w_ecode_a),
        .busy      (w_busy_a)
    );

    uart_cmd_parser #(
        .TIMEOUT_CYCLES (100),
        .DEFAULT_ARG    (1)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .rx_byte   (rx_b),
        .cmd_valid (w_valid_b),
        .cmd_code  (w_code_b),
        .cmd_arg   (w_arg_b),
        .cmd_err   (w_err_b),
        .err_code  (w_ecode_b),
        .busy      (w_busy_b)
    );

    always #5 clk = ~clk;

    // Count and capture every output pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (w_valid_a) begin
            vcnt_a  <= vcnt_a + 1;
            lcode_a <= w_code_a;
            larg_a  <= w_arg_a;
        end
        if (w_err_a) begin
            ecnt_a <= ecnt_a + 1;
            lerr_a <= w_ecode_a;
        end
        if (w_valid_b) begin
            vcnt_b  <= vcnt_b + 1;
            lcode_b <= w_code_b;
            larg_b  <= w_arg_b;
        end
        if (w_err_b) begin
            ecnt_b <= ecnt_b + 1;
            lerr_b <= w_ecode_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one byte for 'hold' cycles, then idle (0) for 3 cycles
    task automatic send_byte(input logic sel, input logic [7:0] b, input int hold);
        if (sel) rx_b = b; else rx_a = b;
        step(hold);
        if (sel) rx_b = 8'h00; else rx_a = 8'h00;
        step(3);
    endtask

    task automatic send_line(input logic sel, input string s, input int hold);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(sel, s[i], hold);
        end
    endtask

    initial begin
        int v0, e0;

        // ---------------- reset state ----------------
        step(3);
        check("rst_valid", {31'd0, w_valid_a}, 32'd0);
        check("rst_code",  {29'd0, w_code_a},  32'd0);
        check("rst_arg",   {28'd0, w_arg_a},   32'd0);
        check("rst_err",   {31'd0, w_err_a},   32'd0);
        check("rst_ecode", {30'd0, w_ecode_a}, 32'd0);
        check("rst_busy",  {31'd0, w_busy_a},  32'd0);
        rst = 1'b0;
        step(3);

        // ---------------- "F3\r" with long-held bytes ----------------
        v0 = vcnt_a; e0 = ecnt_a;
        send_byte(1'b0, 8'h46, 2340);
        send_byte(1'b0, 8'h33, 2340);
        check("f3_busy", {31'd0, w_busy_a}, 32'd1);
        rx_a = 8'h0D;                  // this cycle is the CR accept cycle
        step(1);
        check("f3_valid", {31'd0, w_valid_a}, 32'd1);
        check("f3_code",  {29'd0, w_code_a},  32'd1);
        check("f3_arg",   {28'd0, w_arg_a},   32'd3);
        check("f3_busy0", {31'd0, w_busy_a},  32'd0);
        step(1);
        check("f3_valid_off", {31'd0, w_valid_a}, 32'd0);
        check("f3_code_off",  {29'd0, w_code_a},  32'd0);
        step(2337);
        rx_a = 8'h00;
        step(3);
        check("f3_npulse", vcnt_a - v0, 32'd1);
        check("f3_nerr",   ecnt_a - e0, 32'd0);

        // ---------------- "P\r\n": default arg, LF ignored ----------------
        v0 = vcnt_a; e0 = ecnt_a;
        send_line(1'b0, "P\015\012", 3);
        check("p_npulse", vcnt_a - v0, 32'd1);
        check("p_code",   {29'd0, lcode_a}, 32'd2);
        check("p_arg",    {28'd0, larg_a},  32'd1);
        check("p_nerr",   ecnt_a - e0, 32'd0);
        check("p_busy",   {31'd0, w_busy_a}, 32'd0);

        // ---------------- "F15\r": maximum amount ----------------
        v0 = vcnt_a;
        send_line(1'b0, "F15\015", 3);
        check("f15_npulse", vcnt_a - v0, 32'd1);
        check("f15_code",   {29'd0, lcode_a}, 32'd1);
        check("f15_arg",    {28'd0, larg_a},  32'd15);

        // ---------------- "C16\r": overflow ----------------
        v0 = vcnt_a; e0 = ecnt_a;
        send_line(1'b0, "C16\015", 3);
        check("c16_nerr",   ecnt_a - e0, 32'd1);
        check("c16_ecode",  {30'd0, lerr_a}, 32'd2);
        check("c16_nvalid", vcnt_a - v0, 32'd0);

        // ---------------- "P99\r": large overflow must not wrap ----------------
        v0 = vcnt_a; e0 = ecnt_a;
        send_line(1'b0, "P99\015", 3);
        check("p99_nerr",   ecnt_a - e0, 32'd1);
        check("p99_ecode",  {30'd0, lerr_a}, 32'd2);
        check("p99_nvalid", vcnt_a - v0, 32'd0);

        // ---------------- "F123\r": third digit ----------------
        e0 = ecnt_a;
        send_line(1'b0, "F123\015", 3);
        check("f123_nerr",  ecnt_a - e0, 32'd1);
        check("f123_ecode", {30'd0, lerr_a}, 32'd2);

        // ---------------- "X9\r" then "S2\r" then "?\r" ----------------
        v0 = vcnt_a; e0 = ecnt_a;
        send_line(1'b0, "X9\015", 3);
        check("x9_nerr",  ecnt_a - e0, 32'd1);
        check("x9_ecode", {30'd0, lerr_a}, 32'd1);
        send_line(1'b0, "S2\015", 3);
        check("s2_nerr",  ecnt_a - e0, 32'd2);
        check("s2_ecode", {30'd0, lerr_a}, 32'd2);
        check("xs_nvalid", vcnt_a - v0, 32'd0);
        send_line(1'b0, "?\015", 3);
        check("q_npulse", vcnt_a - v0, 32'd1);
        check("q_code",   {29'd0, lcode_a}, 32'd5);
        check("q_arg",    {28'd0, larg_a},  32'd0);

        // ---------------- lowercase is unknown in the default build ----------------
        e0 = ecnt_a;
        send_line(1'b0, "f\015", 3);
        check("lc_nerr",  ecnt_a - e0, 32'd1);
        check("lc_ecode", {30'd0, lerr_a}, 32'd1);

        // ---------------- timeout on instance B (TIMEOUT_CYCLES=100) ----------------
        v0 = vcnt_b; e0 = ecnt_b;
        rx_b = 8'h46;                  // accept cycle A
        step(99);                      // now in cycle A+99
        check("tmo_early_err", {31'd0, w_err_b},  32'd0);
        check("tmo_busy",      {31'd0, w_busy_b}, 32'd1);
        step(1);                       // cycle A+100
        check("tmo_err",   {31'd0, w_err_b},   32'd1);
        check("tmo_ecode", {30'd0, w_ecode_b}, 32'd3);
        check("tmo_idle",  {31'd0, w_busy_b},  32'd0);
        step(1);
        check("tmo_err_off", {31'd0, w_err_b}, 32'd0);
        rx_b = 8'h00;
        step(3);
        send_line(1'b1, "C\015", 3);
        check("tmo_c_npulse", vcnt_b - v0, 32'd1);
        check("tmo_c_code",   {29'd0, lcode_b}, 32'd3);
        check("tmo_c_arg",    {28'd0, larg_b},  32'd1);
        check("tmo_nerr",     ecnt_b - e0, 32'd1);

        // ---------------- reset mid-line with a byte held ----------------
        send_byte(1'b0, 8'h46, 3);
        send_byte(1'b0, 8'h31, 3);
        check("mid_busy", {31'd0, w_busy_a}, 32'd1);
        v0 = vcnt_a; e0 = ecnt_a;
        rx_a = 8'h46;
        rst  = 1'b1;
        step(2);
        check("mr_busy",  {31'd0, w_busy_a},  32'd0);
        check("mr_valid", {31'd0, w_valid_a}, 32'd0);
        check("mr_err",   {31'd0, w_err_a},   32'd0);
        rst = 1'b0;
        step(10);
        check("mr_hold_busy", {31'd0, w_busy_a}, 32'd0);
        rx_a = 8'h00;
        step(3);
        check("mr_nvalid", vcnt_a - v0, 32'd0);
        check("mr_nerr",   ecnt_a - e0, 32'd0);
        send_line(1'b0, "R\015", 3);
        check("r_npulse", vcnt_a - v0, 32'd1);
        check("r_code",   {29'd0, lcode_a}, 32'd6);
        check("r_arg",    {28'd0, larg_a},  32'd0);
        check("r_nerr",   ecnt_a - e0, 32'd0);
        send_line(1'b0, "\015", 3);
        check("late_cr_nvalid", vcnt_a - v0, 32'd1);
        check("late_cr_nerr",   ecnt_a - e0, 32'd0);
        check("late_cr_busy",   {31'd0, w_busy_a}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
